// File: rtl/sy_ptw_pte_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sy_ptw_pte_fetch : single-outstanding 64-bit PTE read responder.        |
// | Optional PTE buffer enabled by `define SY_PTW_PTE_BUF_EN.               |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module sy_ptw_pte_fetch #(
  parameter int PADDR_W         = 56,
  parameter int TIMEOUT_CYC     = 255,
  parameter int PTE_BUF_ENTRIES = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               ptw_kill_i,
  input  logic               flush_tlb_i,
  input  logic               ptw_req_valid_i,
  output logic               ptw_req_ready_o,
  input  logic [PADDR_W-1:0] ptw_req_paddr_i,
  output logic               ptw_rsp_valid_o,
  output logic [63:0]        ptw_rsp_data_o,
  output logic               ptw_rsp_err_o,
  output logic               mem_ar_valid_o,
  input  logic               mem_ar_ready_i,
  output logic [PADDR_W-1:0] mem_ar_addr_o,
  input  logic               mem_r_valid_i,
  output logic               mem_r_ready_o,
  input  logic [63:0]        mem_r_data_i,
  input  logic               mem_r_err_i
);

  localparam int TAG_W = PADDR_W - 3;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W:0] TMO_LIM = (CNT_W+1)'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   addr_q, addr_d;
  logic               kill_seen_q, kill_seen_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               kill;
  logic [CNT_W:0]     tmo_inc;
  logic               tmo_hit;
  logic               buf_hit;
  logic [63:0]        buf_hit_data;

  assign kill    = flush_i | ptw_kill_i;
  assign tmo_inc = {1'b0, tmo_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_inc == TMO_LIM);

  assign ptw_rsp_valid_o = rsp_valid_q;
  assign ptw_rsp_data_o  = rsp_data_q;
  assign ptw_rsp_err_o   = rsp_err_q;
  assign mem_ar_addr_o   = {addr_q, 3'b000};

`ifdef SY_PTW_PTE_BUF_EN
  localparam int PTR_W = (PTE_BUF_ENTRIES > 1) ? $clog2(PTE_BUF_ENTRIES) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PTE_BUF_ENTRIES - 1);

  logic [PTE_BUF_ENTRIES-1:0] buf_vld_q, buf_vld_d;
  logic [TAG_W-1:0]           buf_tag_q  [PTE_BUF_ENTRIES];
  logic [63:0]                buf_data_q [PTE_BUF_ENTRIES];
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                       buf_fill;

  // Killed, erroring or sfence-coincident beats never enter the buffer.
  assign buf_fill = (state_q == ST_DATA) & mem_r_valid_i & ~kill & ~mem_r_err_i & ~flush_tlb_i;

  always_comb begin
    buf_hit      = 1'b0;
    buf_hit_data = '0;
    for (int i = 0; i < PTE_BUF_ENTRIES; i++) begin
      if (!flush_tlb_i && buf_vld_q[i] && (buf_tag_q[i] == ptw_req_paddr_i[PADDR_W-1:3])) begin
        buf_hit      = 1'b1;
        buf_hit_data = buf_data_q[i];
      end
    end
  end

  always_comb begin
    buf_vld_d = buf_vld_q;
    rr_ptr_d  = rr_ptr_q;
    if (flush_tlb_i) begin
      buf_vld_d = '0;
    end else if (buf_fill) begin
      buf_vld_d[rr_ptr_q] = 1'b1;
      rr_ptr_d = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_vld_q <= '0;
      rr_ptr_q  <= '0;
      for (int i = 0; i < PTE_BUF_ENTRIES; i++) begin
        buf_tag_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      buf_vld_q <= buf_vld_d;
      rr_ptr_q  <= rr_ptr_d;
      if (buf_fill) begin
        buf_tag_q[rr_ptr_q]  <= addr_q;
        buf_data_q[rr_ptr_q] <= mem_r_data_i;
      end
    end
  end
`else
  logic unused_flush_tlb;

  assign unused_flush_tlb = flush_tlb_i;
  assign buf_hit          = 1'b0;
  assign buf_hit_data     = '0;
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    kill_seen_d     = kill_seen_q;
    tmo_cnt_d       = tmo_cnt_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    ptw_req_ready_o = 1'b0;
    mem_ar_valid_o  = 1'b0;
    mem_r_ready_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ptw_req_ready_o = ~kill;
        if (ptw_req_valid_i && !kill) begin
          if (ptw_req_paddr_i[2:0] != 3'b000) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else if (buf_hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = buf_hit_data;
            rsp_err_d   = 1'b0;
          end else begin
            addr_d      = ptw_req_paddr_i[PADDR_W-1:3];
            kill_seen_d = 1'b0;
            state_d     = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        // The address phase cannot be withdrawn, so a kill is remembered and
        // the eventual beat is drained instead.
        mem_ar_valid_o = 1'b1;
        kill_seen_d    = kill_seen_q | kill;
        if (mem_ar_ready_i) begin
          tmo_cnt_d = '0;
          state_d   = (kill_seen_q || kill) ? ST_DRAIN : ST_DATA;
        end
      end

      ST_DATA: begin
        mem_r_ready_o = 1'b1;
        if (mem_r_valid_i) begin
          state_d = ST_IDLE;
          if (!kill) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_r_data_i;
            rsp_err_d   = mem_r_err_i;
          end
        end else if (kill) begin
          state_d = ST_DRAIN;
        end else begin
          if (tmo_cnt_q != {CNT_W{1'b1}}) begin
            tmo_cnt_d = tmo_inc[CNT_W-1:0];
          end
          if (tmo_hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        mem_r_ready_o = 1'b1;
        if (mem_r_valid_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      kill_seen_q <= 1'b0;
      tmo_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      kill_seen_q <= kill_seen_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sy_ptw_pte_fetch.sv
`default_nettype none
// Scoreboard bench for sy_ptw_pte_fetch (TIMEOUT_CYC=8); buffer scenario
// is compiled in when SY_PTW_PTE_BUF_EN is defined.
module tb_sy_ptw_pte_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, ptw_kill_i, flush_tlb_i;
  logic        ptw_req_valid_i, ptw_req_ready_o;
  logic [55:0] ptw_req_paddr_i;
  logic        ptw_rsp_valid_o;
  logic [63:0] ptw_rsp_data_o;
  logic        ptw_rsp_err_o;
  logic        mem_ar_valid_o, mem_ar_ready_i;
  logic [55:0] mem_ar_addr_o;
  logic        mem_r_valid_i, mem_r_ready_o;
  logic [63:0] mem_r_data_i;
  logic        mem_r_err_i;

  int total = 0;
  int bad   = 0;
  int ar_cnt = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  sy_ptw_pte_fetch #(
    .PADDR_W(56), .TIMEOUT_CYC(8), .PTE_BUF_ENTRIES(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .ptw_kill_i(ptw_kill_i),
    .flush_tlb_i(flush_tlb_i), .ptw_req_valid_i(ptw_req_valid_i),
    .ptw_req_ready_o(ptw_req_ready_o), .ptw_req_paddr_i(ptw_req_paddr_i),
    .ptw_rsp_valid_o(ptw_rsp_valid_o), .ptw_rsp_data_o(ptw_rsp_data_o),
    .ptw_rsp_err_o(ptw_rsp_err_o), .mem_ar_valid_o(mem_ar_valid_o),
    .mem_ar_ready_i(mem_ar_ready_i), .mem_ar_addr_o(mem_ar_addr_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o),
    .mem_r_data_i(mem_r_data_i), .mem_r_err_i(mem_r_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Response scoreboard: every pulse must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && ptw_rsp_valid_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got data=%h err=%b, none expected", ptw_rsp_data_o, ptw_rsp_err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ptw_rsp_data_o !== e.data || ptw_rsp_err_o !== e.err) begin
          bad++;
          $display("FAIL rsp_payload: got data=%h err=%b, want data=%h err=%b",
                   ptw_rsp_data_o, ptw_rsp_err_o, e.data, e.err);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni && mem_ar_valid_o && mem_ar_ready_i) ar_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // Drives one request from IDLE and serves the bus with ar_ready=1 and a
  // beat one cycle after the AR handshake; reports response latency.
  task automatic run_read(input logic [55:0] a, input logic [63:0] d, input logic e,
                          output int lat, output bit used_bus);
    bit beat_next;
    lat = -1;
    used_bus = 0;
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = a;
    @(negedge clk_i);
    cyc();
    ptw_req_valid_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (ptw_rsp_valid_o) begin
        lat = c;
        break;
      end
      if (mem_ar_valid_o) used_bus = 1;
      beat_next = mem_ar_valid_o && mem_ar_ready_i;
      cyc();
      mem_r_valid_i = beat_next;
      mem_r_data_i  = d;
      mem_r_err_i   = e;
    end
    cyc();
    mem_r_valid_i = 1'b0;
    mem_r_err_i   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    total++;
    if (ptw_req_ready_o !== 1'b1 || ptw_rsp_valid_o !== 1'b0 || ptw_rsp_data_o !== 64'd0 ||
        ptw_rsp_err_o !== 1'b0 || mem_ar_valid_o !== 1'b0 || mem_ar_addr_o !== 56'd0 ||
        mem_r_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b rv=%b rd=%h re=%b arv=%b ara=%h rr=%b, want 1 0 0 0 0 0 0",
               ptw_req_ready_o, ptw_rsp_valid_o, ptw_rsp_data_o, ptw_rsp_err_o,
               mem_ar_valid_o, mem_ar_addr_o, mem_r_ready_o);
    end
    cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_zero_wait();
    mem_ar_ready_i = 1'b1;
    push_exp(64'h0000_0000_2000_00CF, 1'b0);
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_1000;
    @(negedge clk_i);
    total++;
    if (ptw_req_ready_o !== 1'b1) begin bad++; $display("FAIL zw_accept: got ready=%b want 1", ptw_req_ready_o); end
    cyc();
    ptw_req_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (mem_ar_valid_o !== 1'b1 || mem_ar_addr_o !== 56'h8000_1000) begin
      bad++;
      $display("FAIL zw_ar: got valid=%b addr=%h want 1 80001000", mem_ar_valid_o, mem_ar_addr_o);
    end
    cyc();
    mem_r_valid_i = 1'b1;
    mem_r_data_i  = 64'h0000_0000_2000_00CF;
    mem_r_err_i   = 1'b0;
    @(negedge clk_i);
    total++;
    if (mem_r_ready_o !== 1'b1 || ptw_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL zw_data_phase: got r_ready=%b rsp_valid=%b want 1 0", mem_r_ready_o, ptw_rsp_valid_o);
    end
    cyc();
    mem_r_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ptw_rsp_valid_o !== 1'b1 || ptw_req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL zw_rsp_cycle3: got rsp_valid=%b ready=%b want 1 1", ptw_rsp_valid_o, ptw_req_ready_o);
    end
    cyc();
    @(negedge clk_i);
    total++;
    if (ptw_rsp_valid_o !== 1'b0 || ptw_rsp_data_o !== 64'h2000_00CF) begin
      bad++;
      $display("FAIL zw_pulse_hold: got rsp_valid=%b data=%h want 0 20000cf", ptw_rsp_valid_o, ptw_rsp_data_o);
    end
    cyc();
  endtask

  task automatic test_misaligned();
    int ar0;
    ar0 = ar_cnt;
    push_exp(64'd0, 1'b1);
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_1004;
    @(negedge clk_i);
    cyc();
    ptw_req_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ptw_rsp_valid_o !== 1'b1 || mem_ar_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL misalign_rsp: got rsp_valid=%b ar_valid=%b want 1 0", ptw_rsp_valid_o, mem_ar_valid_o);
    end
    cyc();
    cyc();
    @(negedge clk_i);
    total++;
    if (ar_cnt !== ar0 || mem_ar_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL misalign_no_ar: got ar_count=%0d want %0d", ar_cnt, ar0);
    end
    cyc();
  endtask

  task automatic test_bus_error();
    int lat;
    bit bus;
    push_exp(64'hDEAD_BEEF_0BAD_F00D, 1'b1);
    run_read(56'h8000_3008, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, lat, bus);
    total++;
    if (lat != 3 || !bus) begin
      bad++;
      $display("FAIL bus_err_latency: got lat=%0d bus=%0d want 3 1", lat, bus);
    end
  endtask

  task automatic test_idle_kill();
    push_exp(64'd0, 1'b1);
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_100C;
    @(negedge clk_i);
    cyc();
    ptw_req_valid_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (ptw_rsp_valid_o !== 1'b1 || ptw_req_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_kill: got rsp_valid=%b ready=%b want 1 0", ptw_rsp_valid_o, ptw_req_ready_o);
    end
    cyc();
    flush_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ptw_req_ready_o !== 1'b1) begin bad++; $display("FAIL idle_kill_release: got ready=%b want 1", ptw_req_ready_o); end
    cyc();
  endtask

  task automatic test_kill_data();
    mem_ar_ready_i = 1'b1;
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_4000;
    @(negedge clk_i);
    cyc();
    ptw_req_valid_i = 1'b0;
    cyc();
    ptw_kill_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (mem_r_ready_o !== 1'b1 || ptw_req_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL kdata_in_data: got r_ready=%b ready=%b want 1 0", mem_r_ready_o, ptw_req_ready_o);
    end
    cyc();
    ptw_kill_i = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      if (c == 7) begin
        mem_r_valid_i = 1'b1;
        mem_r_data_i  = 64'h1111_2222_3333_4444;
      end
      @(negedge clk_i);
      total++;
      if (ptw_req_ready_o !== 1'b0) begin bad++; $display("FAIL kdata_drain_ready c%0d: got %b want 0", c, ptw_req_ready_o); end
      cyc();
    end
    mem_r_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ptw_req_ready_o !== 1'b1 || ptw_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL kdata_after_beat: got ready=%b rsp_valid=%b want 1 0", ptw_req_ready_o, ptw_rsp_valid_o);
    end
    cyc();
  endtask

  task automatic test_kill_addr();
    mem_ar_ready_i = 1'b0;
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_5000;
    @(negedge clk_i);
    cyc();
    ptw_req_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      flush_i        = (c == 2);
      mem_ar_ready_i = (c == 5);
      @(negedge clk_i);
      total++;
      if (mem_ar_valid_o !== 1'b1 || mem_ar_addr_o !== 56'h8000_5000) begin
        bad++;
        $display("FAIL kaddr_hold c%0d: got valid=%b addr=%h want 1 80005000", c, mem_ar_valid_o, mem_ar_addr_o);
      end
      cyc();
    end
    flush_i        = 1'b0;
    mem_ar_ready_i = 1'b0;
    mem_r_valid_i  = 1'b1;
    mem_r_data_i   = 64'h5555_5555_5555_5555;
    @(negedge clk_i);
    total++;
    if (mem_ar_valid_o !== 1'b0 || mem_r_ready_o !== 1'b1 || ptw_req_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL kaddr_drain: got ar_valid=%b r_ready=%b ready=%b want 0 1 0",
               mem_ar_valid_o, mem_r_ready_o, ptw_req_ready_o);
    end
    cyc();
    mem_r_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ptw_req_ready_o !== 1'b1 || ptw_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL kaddr_idle: got ready=%b rsp_valid=%b want 1 0", ptw_req_ready_o, ptw_rsp_valid_o);
    end
    mem_ar_ready_i = 1'b1;
    cyc();
  endtask

  task automatic test_timeout();
    int lat;
    bit bus;
    mem_ar_ready_i = 1'b1;
    push_exp(64'd0, 1'b1);
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_6000;
    @(negedge clk_i);
    cyc();
    ptw_req_valid_i = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_i);
      total++;
      if (ptw_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL tmo_early c%0d: got rsp_valid=1 want 0", c); end
      cyc();
    end
    @(negedge clk_i);
    total++;
    if (ptw_rsp_valid_o !== 1'b1) begin bad++; $display("FAIL tmo_rsp: got rsp_valid=%b want 1", ptw_rsp_valid_o); end
    cyc();
    for (int c = 11; c <= 19; c++) begin
      @(negedge clk_i);
      total++;
      if (ptw_req_ready_o !== 1'b0) begin bad++; $display("FAIL tmo_drain c%0d: got ready=%b want 0", c, ptw_req_ready_o); end
      cyc();
    end
    mem_r_valid_i = 1'b1;
    mem_r_data_i  = 64'h6666_6666_6666_6666;
    @(negedge clk_i);
    cyc();
    mem_r_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ptw_req_ready_o !== 1'b1 || ptw_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL tmo_late_beat: got ready=%b rsp_valid=%b want 1 0", ptw_req_ready_o, ptw_rsp_valid_o);
    end
    cyc();
    push_exp(64'h0000_0000_7000_0001, 1'b0);
    run_read(56'h8000_7000, 64'h0000_0000_7000_0001, 1'b0, lat, bus);
    total++;
    if (lat != 3 || !bus) begin bad++; $display("FAIL tmo_next_read: got lat=%0d bus=%0d want 3 1", lat, bus); end
  endtask

  task automatic test_back_to_back();
    mem_ar_ready_i = 1'b1;
    push_exp(64'hAAAA_0000_0000_0001, 1'b0);
    push_exp(64'hBBBB_0000_0000_0002, 1'b0);
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_8000;
    @(negedge clk_i);
    cyc();
    ptw_req_valid_i = 1'b0;
    cyc();
    mem_r_valid_i = 1'b1;
    mem_r_data_i  = 64'hAAAA_0000_0000_0001;
    cyc();
    mem_r_valid_i   = 1'b0;
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h8000_9000;
    @(negedge clk_i);
    total++;
    if (ptw_rsp_valid_o !== 1'b1 || ptw_req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_overlap: got rsp_valid=%b ready=%b want 1 1", ptw_rsp_valid_o, ptw_req_ready_o);
    end
    cyc();
    ptw_req_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (mem_ar_valid_o !== 1'b1 || mem_ar_addr_o !== 56'h8000_9000) begin
      bad++;
      $display("FAIL b2b_second_ar: got valid=%b addr=%h want 1 80009000", mem_ar_valid_o, mem_ar_addr_o);
    end
    cyc();
    mem_r_valid_i = 1'b1;
    mem_r_data_i  = 64'hBBBB_0000_0000_0002;
    cyc();
    mem_r_valid_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ptw_rsp_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_second_rsp: got rsp_valid=%b want 1", ptw_rsp_valid_o); end
    cyc();
  endtask

`ifdef SY_PTW_PTE_BUF_EN
  task automatic test_buffer();
    int lat;
    bit bus;
    logic [55:0] a;
    mem_ar_ready_i = 1'b1;
    flush_tlb_i = 1'b1;
    cyc();
    flush_tlb_i = 1'b0;
    push_exp(64'h0000_0000_2000_1001, 1'b0);
    run_read(56'h8000_2000, 64'h0000_0000_2000_1001, 1'b0, lat, bus);
    total++;
    if (lat != 3 || !bus) begin bad++; $display("FAIL buf_first_miss: got lat=%0d bus=%0d want 3 1", lat, bus); end
    push_exp(64'h0000_0000_2000_1001, 1'b0);
    run_read(56'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, bus);
    total++;
    if (lat != 1 || bus) begin bad++; $display("FAIL buf_hit: got lat=%0d bus=%0d want 1 0", lat, bus); end
    flush_tlb_i = 1'b1;
    cyc();
    flush_tlb_i = 1'b0;
    push_exp(64'h0000_0000_2000_2002, 1'b0);
    run_read(56'h8000_2000, 64'h0000_0000_2000_2002, 1'b0, lat, bus);
    total++;
    if (lat != 3 || !bus) begin bad++; $display("FAIL buf_after_sfence: got lat=%0d bus=%0d want 3 1", lat, bus); end
    flush_tlb_i = 1'b1;
    cyc();
    flush_tlb_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 56'h8001_0000 + 56'(i) * 56'h1000;
      push_exp(64'hC0DE_0000_0000_0000 + 64'(i), 1'b0);
      run_read(a, 64'hC0DE_0000_0000_0000 + 64'(i), 1'b0, lat, bus);
    end
    push_exp(64'hC0DE_0000_0000_0001, 1'b0);
    run_read(56'h8001_1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, bus);
    total++;
    if (lat != 1 || bus) begin bad++; $display("FAIL buf_keep_second: got lat=%0d bus=%0d want 1 0", lat, bus); end
    push_exp(64'hC0DE_0000_0000_0010, 1'b0);
    run_read(56'h8001_0000, 64'hC0DE_0000_0000_0010, 1'b0, lat, bus);
    total++;
    if (lat != 3 || !bus) begin bad++; $display("FAIL buf_evict_first: got lat=%0d bus=%0d want 3 1", lat, bus); end
  endtask
`endif

  initial begin
    rst_ni          = 1'b0;
    flush_i         = 1'b0;
    ptw_kill_i      = 1'b0;
    flush_tlb_i     = 1'b0;
    ptw_req_valid_i = 1'b0;
    ptw_req_paddr_i = '0;
    mem_ar_ready_i  = 1'b0;
    mem_r_valid_i   = 1'b0;
    mem_r_data_i    = '0;
    mem_r_err_i     = 1'b0;
    cyc();
    test_reset();
    test_zero_wait();
    test_misaligned();
    test_bus_error();
    test_idle_kill();
    test_kill_data();
    test_kill_addr();
    test_timeout();
    test_back_to_back();
`ifdef SY_PTW_PTE_BUF_EN
    test_buffer();
`endif
    cyc();
    cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rsp_missing: got %0d expected responses never seen, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
